// File: rtl/ota_test_pkg.sv
// Shared types and constants for the digital-OTA test chain read-out blocks.
package ota_test_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    localparam int unsigned WIN_LOG2_DEFAULT = 8;

    // Result width must hold the full-scale count 2^win_log2, hence one extra bit.
    function automatic int unsigned res_w(input int unsigned win_log2);
        return win_log2 + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pad inputs.
module sync_2ff #(
    parameter int unsigned W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ota_bitstream_decimator.sv
// Sinc1 decimator: counts ones of the synchronised OTA bitstream over 2^WIN_LOG2 clocks
// and presents each window count with a valid/ack handshake.
module ota_bitstream_decimator
    import ota_test_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = WIN_LOG2_DEFAULT,
    parameter int unsigned RES_W    = res_w(WIN_LOG2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             enable,
    input  logic             ack,
    input  logic             clr_ovr,
    output logic [RES_W-1:0] result,
    output logic             valid,
    output logic             overrun,
    output logic             busy
);

    localparam logic [WIN_LOG2-1:0] CNT_MAX = '1;

    logic bit_s;

    run_state_e          state_q, state_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0]    acc_q, acc_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                busy_q, busy_d;

    sync_2ff #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bit_in),
        .q     (bit_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, window counting and handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (ack && valid_q) begin
            valid_d = 1'b0;
        end
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                acc_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Abort: partial window is dropped, published result untouched.
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    result_d = acc_q + RES_W'(bit_s);
                    valid_d  = 1'b1;
                    // A concurrent ack consumes the old word, so only an unacked one is lost.
                    if (valid_q && !ack) begin
                        overrun_d = 1'b1;
                    end
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = acc_q + RES_W'(bit_s);
                    cnt_d = cnt_q + WIN_LOG2'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    assign result  = result_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Directed bench for ota_bitstream_decimator with a 16-clock window.
module tb_ota_bitstream_decimator;

    localparam int unsigned WIN_LOG2 = 4;
    localparam int unsigned RES_W    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             bit_in;
    logic             enable;
    logic             ack;
    logic             clr_ovr;
    logic [RES_W-1:0] result;
    logic             valid;
    logic             overrun;
    logic             busy;

    int checks = 0;
    int errors = 0;

    ota_bitstream_decimator #(
        .WIN_LOG2 (WIN_LOG2),
        .RES_W    (RES_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_in  (bit_in),
        .enable  (enable),
        .ack     (ack),
        .clr_ovr (clr_ovr),
        .result  (result),
        .valid   (valid),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Acknowledge any pending result and drop enable on the same edge.
    task automatic stop_and_ack();
        enable = 1'b0;
        ack    = 1'b1;
        tick(1);
        ack    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bit_in = 1'b0; enable = 1'b0; ack = 1'b0; clr_ovr = 1'b0;
        tick(3);
        checks++; if (result !== 5'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        checks++; if ({valid, overrun, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {valid, overrun, busy}); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_all_ones();
        bit_in = 1'b1;
        tick(3);
        enable = 1'b1;
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ones_busy: got %b want 1", busy); end
        tick(15);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid: got %b want 0", valid); end
        tick(1);
        checks++; if (valid !== 1'b1 || result !== 5'd16) begin errors++; $display("FAIL ones_first: got valid=%b result=%0d want valid=1 result=16", valid, result); end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ones_ack_clear: got %b want 0", valid); end
        tick(15);
        checks++; if (valid !== 1'b1 || result !== 5'd16 || overrun !== 1'b0) begin errors++; $display("FAIL ones_second: got valid=%b result=%0d ovr=%b want 1/16/0", valid, result, overrun); end
        stop_and_ack();
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL ones_stop: got busy=%b valid=%b want 0/0", busy, valid); end
    endtask

    task automatic test_patterns();
        // Alternating bitstream: any 16 consecutive samples hold 8 ones.
        for (int i = 0; i < 4; i++) begin
            bit_in = ~bit_in;
            tick(1);
        end
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bit_in = ~bit_in;
            tick(1);
        end
        checks++; if (valid !== 1'b1 || result !== 5'd8) begin errors++; $display("FAIL toggle: got valid=%b result=%0d want 1/8", valid, result); end
        stop_and_ack();

        bit_in = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(17);
        checks++; if (valid !== 1'b1 || result !== 5'd0) begin errors++; $display("FAIL zeros: got valid=%b result=%0d want 1/0", valid, result); end
        stop_and_ack();

        // Pattern starts together with enable: first sample still sees the old 0.
        tick(2);
        bit_in = 1'b1;
        enable = 1'b1;
        tick(17);
        checks++; if (valid !== 1'b1 || result !== 5'd15) begin errors++; $display("FAIL sync_latency: got valid=%b result=%0d want 1/15", valid, result); end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(15);
        checks++; if (valid !== 1'b1 || result !== 5'd16) begin errors++; $display("FAIL sync_second: got valid=%b result=%0d want 1/16", valid, result); end
        stop_and_ack();
    endtask

    task automatic test_overrun();
        bit_in = 1'b1;
        tick(3);
        enable = 1'b1;
        tick(17);
        checks++; if (valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got valid=%b ovr=%b want 1/0", valid, overrun); end
        tick(16);
        checks++; if (overrun !== 1'b1 || result !== 5'd16 || valid !== 1'b1) begin errors++; $display("FAIL ovr_set: got ovr=%b result=%0d valid=%b want 1/16/1", overrun, result, valid); end
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL ovr_clear: got ovr=%b valid=%b want 0/1", overrun, valid); end
        tick(14);
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        clr_ovr = 1'b1;
        stop_and_ack();
        clr_ovr = 1'b0;
        checks++; if ({valid, overrun, busy} !== 3'b000) begin errors++; $display("FAIL ovr_cleanup: got %b want 000", {valid, overrun, busy}); end
    endtask

    task automatic test_ack_on_load();
        bit_in = 1'b1;
        tick(3);
        enable = 1'b1;
        tick(17);
        bit_in = 1'b0;
        checks++; if (valid !== 1'b1 || result !== 5'd16) begin errors++; $display("FAIL ackload_first: got valid=%b result=%0d want 1/16", valid, result); end
        tick(15);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        // Second window only sees the two ones still in the synchroniser.
        checks++; if (valid !== 1'b1 || overrun !== 1'b0 || result !== 5'd2) begin errors++; $display("FAIL ackload: got valid=%b ovr=%b result=%0d want 1/0/2", valid, overrun, result); end
        stop_and_ack();
    endtask

    task automatic test_enable_drop();
        bit_in = 1'b1;
        tick(3);
        enable = 1'b1;
        tick(8);
        enable = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || result !== 5'd2) begin errors++; $display("FAIL drop: got busy=%b valid=%b result=%0d want 0/0/2", busy, valid, result); end
        tick(4);
        checks++; if (valid !== 1'b0 || result !== 5'd2) begin errors++; $display("FAIL drop_hold: got valid=%b result=%0d want 0/2", valid, result); end
        enable = 1'b1;
        tick(16);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reenable_early: got %b want 0", valid); end
        tick(1);
        checks++; if (valid !== 1'b1 || result !== 5'd16) begin errors++; $display("FAIL reenable: got valid=%b result=%0d want 1/16", valid, result); end
    endtask

    task automatic test_reset_mid();
        tick(5);
        #2;
        rst_n  = 1'b0;
        #1;
        checks++; if (result !== 5'd0 || {valid, overrun, busy} !== 3'b000) begin errors++; $display("FAIL async_reset: got result=%0d flags=%b want 0/000", result, {valid, overrun, busy}); end
        enable = 1'b0;
        tick(2);
        #3;
        rst_n = 1'b1;
        tick(20);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got valid=%b busy=%b want 0/0", valid, busy); end
        enable = 1'b1;
        tick(16);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_reset_early: got %b want 0", valid); end
        tick(1);
        checks++; if (valid !== 1'b1 || result !== 5'd16) begin errors++; $display("FAIL post_reset_window: got valid=%b result=%0d want 1/16", valid, result); end
        stop_and_ack();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_overrun();
        test_ack_on_load();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
